stepmotor_profile_sequencer: RTL and testbench

- Sequences one step-motor pulse-generator channel through a trapezoidal or triangular speed profile.
- Breaks a total step count into segments of at most cfg_seg_pulses pulses. Writes {en, cw, stop_n, period} plus the segment pulse count to the channel.
- Waits for the channel's done level, then re-arms the channel. Sits between the FSMC register file and one driver channel, one instance per axis.

---
 rtl/stepmotor_profile_sequencer_if.sv | 32 +++
 rtl/stepmotor_profile_sequencer.sv | 168 ++++++++++++++++
 tb/tb_stepmotor_profile_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stepmotor_profile_sequencer_if.sv
// Handshake and configuration bundle between the register file / bench and one axis sequencer.
// The sequencer takes the slave side; the host/channel model takes the master side.
interface stepmotor_profile_sequencer_if;
  logic        start;
  logic        abort;
  logic        dir;
  logic [15:0] cfg_total_steps;
  logic [12:0] cfg_start_period;
  logic [12:0] cfg_min_period;
  logic [12:0] cfg_delta;
  logic [7:0]  cfg_seg_pulses;
  logic        drv_int;
  logic [15:0] drv_register;
  logic [7:0]  drv_pul_num;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        err;
  logic [15:0] steps_done;

  modport master (
    output start, abort, dir, cfg_total_steps, cfg_start_period, cfg_min_period,
           cfg_delta, cfg_seg_pulses, drv_int,
    input  drv_register, drv_pul_num, busy, done, aborted, err, steps_done
  );

  modport slave (
    input  start, abort, dir, cfg_total_steps, cfg_start_period, cfg_min_period,
           cfg_delta, cfg_seg_pulses, drv_int,
    output drv_register, drv_pul_num, busy, done, aborted, err, steps_done
  );
endinterface

// File: rtl/stepmotor_profile_sequencer.sv
// Splits a move into pulse segments following a trapezoidal/triangular period profile and
// hands each segment to one pulse-generator channel, re-arming it between segments.
module stepmotor_profile_sequencer #(
  parameter logic EN_ACTIVE    = 1'b1,
  parameter int   REARM_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  stepmotor_profile_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, PLAN, LOAD, ARM, RUN, UPDATE, FINISH} state_t;
  typedef enum logic [1:0] {PH_CRUISE, PH_ACCEL, PH_DECEL} phase_t;

  localparam logic [4:0] REARM = 5'(REARM_CYCLES);

  state_t      state, nextState;
  phase_t      phase, planPhase;

  logic [15:0] remSteps, rampSum, stepsDone;
  logic [12:0] period, startPer, minPer, deltaLat;
  logic [7:0]  segMax, segN, planN;
  logic        dirLat;
  logic [3:0]  armCnt;

  logic        drvEn, drvCw, drvStopN;
  logic [12:0] drvPeriod;
  logic [7:0]  drvPulNum;
  logic        busyR, doneR, abortedR, errR;

  logic        cfgValid, abortHit, armDone;
  logic [13:0] periodUp, periodDn;
  logic [12:0] planPeriod, accelPeriod;
  logic [15:0] remMinusA, rampDec;
  logic [17:0] accelNeed;

  assign cfgValid = (bus.cfg_min_period != '0) && (bus.cfg_start_period >= bus.cfg_min_period)
                 && (bus.cfg_seg_pulses != '0);
  assign abortHit = bus.abort && (state != IDLE);
  assign armDone  = ({1'b0, armCnt} + 5'd1) >= REARM;

  // Segment planning: decel once the remaining steps fit inside the ramp already built,
  // accel while there is room to ramp back down symmetrically, otherwise cruise.
  always_comb begin
    periodUp    = {1'b0, period} + {1'b0, deltaLat};
    periodDn    = {1'b0, period} - {1'b0, deltaLat};
    accelPeriod = (periodDn[13] || periodDn[12:0] < minPer) ? minPer : periodDn[12:0];
    remMinusA   = remSteps - rampSum;
    accelNeed   = {({1'b0, rampSum} + {9'b0, segMax}), 1'b0};
    rampDec     = (rampSum > {8'b0, segN}) ? rampSum - {8'b0, segN} : '0;
    planPhase   = PH_CRUISE;
    planPeriod  = period;
    planN       = segMax;
    if (remSteps <= rampSum) begin
      planPhase  = PH_DECEL;
      planPeriod = (periodUp > {1'b0, startPer}) ? startPer : periodUp[12:0];
      planN      = (remSteps < {8'b0, segMax}) ? remSteps[7:0] : segMax;
    end else if (period > minPer && {2'b0, remSteps} >= accelNeed) begin
      planPhase  = PH_ACCEL;
    end else begin
      planN      = (remMinusA < {8'b0, segMax}) ? remMinusA[7:0] : segMax;
    end
  end

  always_comb begin
    nextState = state;
    if (abortHit) nextState = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start && !bus.abort && cfgValid) nextState = PLAN;
        PLAN:    nextState = (remSteps == '0) ? FINISH : LOAD;
        LOAD:    nextState = ARM;
        ARM:     if (armDone && !bus.drv_int) nextState = RUN;
        RUN:     if (bus.drv_int) nextState = UPDATE;
        UPDATE:  nextState = PLAN;
        FINISH:  nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remSteps <= '0; rampSum <= '0; period <= '0; stepsDone <= '0;
      startPer <= '0; minPer <= '0; deltaLat <= '0; segMax <= '0; segN <= '0;
      dirLat <= 1'b0; phase <= PH_CRUISE; armCnt <= '0;
      drvEn <= ~EN_ACTIVE; drvCw <= 1'b0; drvStopN <= 1'b0; drvPeriod <= '0; drvPulNum <= '0;
      busyR <= 1'b0; doneR <= 1'b0; abortedR <= 1'b0; errR <= 1'b0;
    end else begin
      doneR    <= 1'b0;
      abortedR <= 1'b0;
      errR     <= 1'b0;
      if (abortHit) begin
        // Partial segment is dropped: stepsDone only advances in UPDATE.
        abortedR <= 1'b1;
        busyR    <= 1'b0;
        drvStopN <= 1'b0;
        drvEn    <= ~EN_ACTIVE;
      end else begin
        case (state)
          IDLE: if (bus.start && !bus.abort) begin
            if (!cfgValid) errR <= 1'b1;
            else begin
              startPer  <= bus.cfg_start_period;
              minPer    <= bus.cfg_min_period;
              deltaLat  <= bus.cfg_delta;
              segMax    <= bus.cfg_seg_pulses;
              dirLat    <= bus.dir;
              remSteps  <= bus.cfg_total_steps;
              rampSum   <= '0;
              period    <= bus.cfg_start_period;
              stepsDone <= '0;
              busyR     <= 1'b1;
            end
          end
          PLAN: if (remSteps != '0) begin
            segN   <= planN;
            phase  <= planPhase;
            period <= planPeriod;
          end
          LOAD: begin
            drvEn     <= EN_ACTIVE;
            drvCw     <= dirLat;
            drvStopN  <= 1'b0;
            drvPeriod <= period;
            drvPulNum <= segN;
            armCnt    <= '0;
          end
          ARM: begin
            if (armCnt != 4'hF) armCnt <= armCnt + 4'd1;
            if (armDone && !bus.drv_int) drvStopN <= 1'b1;
          end
          RUN: if (bus.drv_int) drvStopN <= 1'b0;
          UPDATE: begin
            stepsDone <= stepsDone + {8'b0, segN};
            remSteps  <= remSteps - {8'b0, segN};
            if (phase == PH_ACCEL) begin
              rampSum <= rampSum + {8'b0, segN};
              period  <= accelPeriod;
            end else if (phase == PH_DECEL) begin
              rampSum <= rampDec;
            end
          end
          FINISH: begin
            doneR <= 1'b1;
            busyR <= 1'b0;
            drvEn <= ~EN_ACTIVE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.drv_register = {drvEn, drvCw, drvStopN, drvPeriod};
  assign bus.drv_pul_num  = drvPulNum;
  assign bus.busy         = busyR;
  assign bus.done         = doneR;
  assign bus.aborted      = abortedR;
  assign bus.err          = errR;
  assign bus.steps_done   = stepsDone;

endmodule

// File: tb/tb_stepmotor_profile_sequencer.sv
// Directed bench for the step-motor profile sequencer with a simple channel model in tasks.
module tb_stepmotor_profile_sequencer;
  logic clk, reset_n;
  int   passCnt = 0, totalCnt = 0;
  int   doneCnt = 0, errCnt = 0, stopHighCnt = 0;
  int   expP[8], expN[8];

  stepmotor_profile_sequencer_if bus();

  stepmotor_profile_sequencer #(.EN_ACTIVE(1'b1), .REARM_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) doneCnt++;
    if (bus.err === 1'b1) errCnt++;
    if (bus.drv_register[13] === 1'b1) stopHighCnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setCfg(input logic [15:0] tot, input logic [12:0] sp, input logic [12:0] mp,
                        input logic [12:0] dl, input logic [7:0] seg);
    bus.cfg_total_steps = tot; bus.cfg_start_period = sp; bus.cfg_min_period = mp;
    bus.cfg_delta = dl; bus.cfg_seg_pulses = seg;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitStop(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.drv_register[13] === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic runMove(input string name, input logic [15:0] tot, input logic [12:0] sp,
                         input logic [12:0] mp, input logic [12:0] dl, input logic [7:0] seg,
                         input int nSeg);
    int d0, e0; bit ok;
    logic [15:0] expReg;
    d0 = doneCnt; e0 = errCnt;
    setCfg(tot, sp, mp, dl, seg);
    pulseStart();
    // Scramble cfg mid-move; the latched copy must be used.
    setCfg(16'd3, 13'd7, 13'd0, 13'd1, 8'd1);
    for (int s = 0; s < nSeg; s++) begin
      waitStop(1'b1, ok);
      totalCnt++;
      if (!ok) begin $display("FAIL %s seg%0d stop_n rise: timed out, required high", name, s); return; end
      passCnt++;
      expReg = {3'b111, 13'(expP[s])};
      totalCnt++;
      if (bus.drv_register !== expReg) $display("FAIL %s seg%0d drv_register: got %h want %h", name, s, bus.drv_register, expReg);
      else passCnt++;
      totalCnt++;
      if (bus.drv_pul_num !== 8'(expN[s])) $display("FAIL %s seg%0d drv_pul_num: got %0d want %0d", name, s, bus.drv_pul_num, expN[s]);
      else passCnt++;
      if (s == 1) pulseStart();
      repeat (3) @(negedge clk);
      bus.drv_int = 1'b1;
      waitStop(1'b0, ok);
      bus.drv_int = 1'b0;
    end
    for (int i = 0; i < 50; i++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    @(negedge clk);
    totalCnt++;
    if (bus.busy !== 1'b0) $display("FAIL %s busy after move: got %b want 0", name, bus.busy); else passCnt++;
    totalCnt++;
    if (doneCnt - d0 != 1) $display("FAIL %s done pulses: got %0d want 1", name, doneCnt - d0); else passCnt++;
    totalCnt++;
    if (bus.steps_done !== tot) $display("FAIL %s steps_done: got %0d want %0d", name, bus.steps_done, tot); else passCnt++;
    totalCnt++;
    if (bus.drv_register[15] !== 1'b0) $display("FAIL %s en after move: got %b want 0", name, bus.drv_register[15]); else passCnt++;
    totalCnt++;
    if (errCnt != e0) $display("FAIL %s err while busy: got %0d want 0", name, errCnt - e0); else passCnt++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 0; bus.abort = 0; bus.dir = 1'b1; bus.drv_int = 0;
    setCfg(16'd0, 13'd0, 13'd0, 13'd0, 8'd0);
    repeat (3) @(negedge clk);
    totalCnt++;
    if (bus.drv_register !== 16'h0000) $display("FAIL reset drv_register: got %h want 0000", bus.drv_register); else passCnt++;
    totalCnt++;
    if (bus.drv_pul_num !== 8'd0) $display("FAIL reset drv_pul_num: got %0d want 0", bus.drv_pul_num); else passCnt++;
    totalCnt++;
    if ({bus.busy, bus.done, bus.aborted, bus.err} !== 4'b0000)
      $display("FAIL reset flags: got %b want 0000", {bus.busy, bus.done, bus.aborted, bus.err});
    else passCnt++;
    totalCnt++;
    if (bus.steps_done !== 16'd0) $display("FAIL reset steps_done: got %0d want 0", bus.steps_done); else passCnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cruise();
    expP = '{100, 100, 100, 0, 0, 0, 0, 0};
    expN = '{4, 4, 2, 0, 0, 0, 0, 0};
    runMove("cruise", 16'd10, 13'd100, 13'd100, 13'd5, 8'd4, 3);
  endtask

  task automatic test_trapezoid();
    expP = '{40, 30, 20, 10, 10, 20, 30, 40};
    expN = '{8, 8, 8, 8, 8, 8, 8, 8};
    runMove("trapezoid", 16'd64, 13'd40, 13'd10, 13'd10, 8'd8, 8);
  endtask

  task automatic test_triangle();
    expP = '{40, 30, 40, 0, 0, 0, 0, 0};
    expN = '{8, 4, 8, 0, 0, 0, 0, 0};
    runMove("triangle", 16'd20, 13'd40, 13'd10, 13'd10, 8'd8, 3);
  endtask

  task automatic test_invalid();
    setCfg(16'd10, 13'd100, 13'd0, 13'd5, 8'd4);
    pulseStart();
    totalCnt++;
    if (bus.err !== 1'b1) $display("FAIL invalid min0 err: got %b want 1", bus.err); else passCnt++;
    totalCnt++;
    if (bus.busy !== 1'b0) $display("FAIL invalid min0 busy: got %b want 0", bus.busy); else passCnt++;
    totalCnt++;
    if (bus.drv_register !== 16'h4028) $display("FAIL invalid min0 drv_register: got %h want 4028", bus.drv_register); else passCnt++;
    @(negedge clk);
    setCfg(16'd10, 13'd5, 13'd9, 13'd5, 8'd4);
    pulseStart();
    totalCnt++;
    if (bus.err !== 1'b1) $display("FAIL invalid start<min err: got %b want 1", bus.err); else passCnt++;
    @(negedge clk);
    totalCnt++;
    if ({bus.busy, bus.err} !== 2'b00) $display("FAIL invalid start<min after: got %b want 00", {bus.busy, bus.err}); else passCnt++;
  endtask

  task automatic test_zero_total();
    int d0, h0;
    d0 = doneCnt; h0 = stopHighCnt;
    setCfg(16'd0, 13'd100, 13'd100, 13'd5, 8'd4);
    pulseStart();
    repeat (6) @(negedge clk);
    totalCnt++;
    if (doneCnt - d0 != 1) $display("FAIL zero done pulses: got %0d want 1", doneCnt - d0); else passCnt++;
    totalCnt++;
    if (stopHighCnt != h0) $display("FAIL zero stop_n high cycles: got %0d want 0", stopHighCnt - h0); else passCnt++;
    totalCnt++;
    if (bus.busy !== 1'b0 || bus.steps_done !== 16'd0)
      $display("FAIL zero busy/steps: got %b/%0d want 0/0", bus.busy, bus.steps_done);
    else passCnt++;
  endtask

  task automatic test_abort();
    int d0; bit ok;
    d0 = doneCnt;
    setCfg(16'd10, 13'd100, 13'd100, 13'd5, 8'd4);
    pulseStart();
    waitStop(1'b1, ok);
    repeat (3) @(negedge clk);
    bus.drv_int = 1'b1;
    waitStop(1'b0, ok);
    bus.drv_int = 1'b0;
    waitStop(1'b1, ok);
    totalCnt++;
    if (!ok) $display("FAIL abort seg1 stop_n rise: timed out, required high"); else passCnt++;
    repeat (4) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    totalCnt++;
    if (bus.drv_register[15:13] !== 3'b010) $display("FAIL abort en/cw/stop_n: got %b want 010", bus.drv_register[15:13]); else passCnt++;
    totalCnt++;
    if (bus.aborted !== 1'b1 || bus.busy !== 1'b0) $display("FAIL abort aborted/busy: got %b/%b want 1/0", bus.aborted, bus.busy); else passCnt++;
    totalCnt++;
    if (bus.steps_done !== 16'd4) $display("FAIL abort steps_done: got %0d want 4", bus.steps_done); else passCnt++;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (doneCnt != d0 || bus.aborted !== 1'b0) $display("FAIL abort done/aborted after: got %0d/%b want 0/0", doneCnt - d0, bus.aborted); else passCnt++;
  endtask

  task automatic test_back_to_back();
    expP = '{100, 100, 100, 0, 0, 0, 0, 0};
    expN = '{4, 4, 2, 0, 0, 0, 0, 0};
    runMove("restart", 16'd10, 13'd100, 13'd100, 13'd5, 8'd4, 3);
  endtask

  task automatic test_int_hold();
    int h0; bit ok;
    setCfg(16'd10, 13'd100, 13'd100, 13'd5, 8'd4);
    pulseStart();
    waitStop(1'b1, ok);
    repeat (2) @(negedge clk);
    bus.drv_int = 1'b1;
    waitStop(1'b0, ok);
    h0 = stopHighCnt;
    repeat (10) @(negedge clk);
    totalCnt++;
    if (stopHighCnt != h0) $display("FAIL inthold stop_n while int high: got %0d high cycles want 0", stopHighCnt - h0); else passCnt++;
    bus.drv_int = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (bus.drv_register[13] !== 1'b1) $display("FAIL inthold stop_n after int drop: got %b want 1", bus.drv_register[13]); else passCnt++;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    totalCnt++;
    if (bus.aborted !== 1'b1 || bus.steps_done !== 16'd4) $display("FAIL inthold abort/steps: got %b/%0d want 1/4", bus.aborted, bus.steps_done); else passCnt++;
  endtask

  task automatic test_reset_midmove();
    bit ok;
    setCfg(16'd10, 13'd100, 13'd100, 13'd5, 8'd4);
    pulseStart();
    waitStop(1'b1, ok);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    totalCnt++;
    if (bus.drv_register !== 16'h0000) $display("FAIL midreset drv_register: got %h want 0000", bus.drv_register); else passCnt++;
    totalCnt++;
    if (bus.drv_pul_num !== 8'd0 || bus.busy !== 1'b0) $display("FAIL midreset pul/busy: got %0d/%b want 0/0", bus.drv_pul_num, bus.busy); else passCnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cruise();
    test_trapezoid();
    test_triangle();
    test_invalid();
    test_zero_total();
    test_abort();
    test_back_to_back();
    test_int_hold();
    test_reset_midmove();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
